// File: rtl/adam_dom_sequencer_pkg.sv
// Shared types for the domain power-up / pause sequencer.
package adam_dom_sequencer_pkg;

   // Sequencer phases, in the order a normal power-up walks through them.
   typedef enum logic [2:0] {
      ST_INIT,
      ST_REL,
      ST_RESUME,
      ST_RUN,
      ST_PAUSE,
      ST_PAUSED,
      ST_ERR
   } dom_seq_state_t;

   // Command remembered while a sequence is still in progress.
   typedef enum logic [1:0] {
      CMD_NONE,
      CMD_PAUSE,
      CMD_RESUME
   } dom_seq_cmd_t;

   // Width of a domain index; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/adam_dom_sequencer_timer.sv
// Clearable up-counter with a terminal-value flag; serves both the reset
// hold time and the per-domain handshake timeout.
module adam_dom_sequencer_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic [WIDTH-1:0] term_val_i,
   output logic             term_o
);

   logic [WIDTH-1:0] cnt_q;

   // Count register: clear has priority over increment.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (inc_i) begin
         cnt_q <= cnt_q + WIDTH'(1);
      end
   end

   assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/adam_dom_sequencer.sv
// Power-up and pause sequencer for the SoC clock/power domains: holds all
// domain resets, releases them one per cycle, then walks the pause req/ack
// handshake up (resume) or down (pause) the domain list.
module adam_dom_sequencer
   import adam_dom_sequencer_pkg::*;
#(
   parameter int unsigned NO_DOMS    = 2,
   parameter int unsigned RST_CYCLES = 16,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           pause_i,
   input  logic                           resume_i,
   output logic [NO_DOMS-1:0]             dom_rst_o,
   output logic [NO_DOMS-1:0]             dom_pause_req_o,
   input  logic [NO_DOMS-1:0]             dom_pause_ack_i,
   output logic                           busy_o,
   output logic                           running_o,
   output logic                           err_o,
   output logic [idx_width(NO_DOMS)-1:0]  err_dom_o
);

   localparam int unsigned KW      = idx_width(NO_DOMS);
   localparam int unsigned CNT_MAX = (RST_CYCLES > TIMEOUT) ? RST_CYCLES : TIMEOUT;
   localparam int unsigned TW      = $clog2(CNT_MAX + 1);
   localparam logic [KW-1:0] LAST  = KW'(NO_DOMS - 1);

   dom_seq_state_t   state_q, state_d;
   dom_seq_cmd_t     pend_q, pend_d, pend_l, cmd_in;
   logic [KW-1:0]    k_q, k_d;
   logic [KW-1:0]    err_dom_q, err_dom_d;
   logic [NO_DOMS-1:0] dom_rst_q, dom_rst_d;
   logic [NO_DOMS-1:0] req_q, req_d;
   logic             tmr_clr, tmr_inc, tmr_term;
   logic [TW-1:0]    tmr_term_val;

   // The same counter times the reset hold in INIT and the ack wait elsewhere.
   assign tmr_term_val = (state_q == ST_INIT) ? TW'(RST_CYCLES - 1) : TW'(TIMEOUT - 1);

   adam_dom_sequencer_timer #(
      .WIDTH (TW)
   ) u_timer (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clr_i      (tmr_clr),
      .inc_i      (tmr_inc),
      .term_val_i (tmr_term_val),
      .term_o     (tmr_term)
   );

   // State and sequencing registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_INIT;
         pend_q    <= CMD_NONE;
         k_q       <= '0;
         err_dom_q <= '0;
         dom_rst_q <= '1;
         req_q     <= '1;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         k_q       <= k_d;
         err_dom_q <= err_dom_d;
         dom_rst_q <= dom_rst_d;
         req_q     <= req_d;
      end
   end

   // Next-state logic; req_q records each domain's level once its ack lands,
   // so ERR can freeze the request pattern exactly as last driven.
   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      k_d       = k_q;
      err_dom_d = err_dom_q;
      dom_rst_d = dom_rst_q;
      req_d     = req_q;
      tmr_clr   = 1'b0;
      tmr_inc   = 1'b0;
      cmd_in    = pause_i ? CMD_PAUSE : (resume_i ? CMD_RESUME : CMD_NONE);
      pend_l    = (cmd_in != CMD_NONE) ? cmd_in : pend_q;
      unique case (state_q)
         ST_INIT: begin
            pend_d = pend_l;
            if (tmr_term) begin
               state_d = ST_REL;
               k_d     = '0;
               tmr_clr = 1'b1;
            end else begin
               tmr_inc = 1'b1;
            end
         end
         ST_REL: begin
            pend_d         = pend_l;
            tmr_clr        = 1'b1;
            dom_rst_d[k_q] = 1'b0;
            if (k_q == LAST) begin
               state_d = ST_RESUME;
               k_d     = '0;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         ST_RESUME: begin
            pend_d = pend_l;
            if (!dom_pause_ack_i[k_q]) begin
               req_d[k_q] = 1'b0;
               tmr_clr    = 1'b1;
               if (k_q == LAST) begin
                  state_d = ST_RUN;
                  k_d     = '0;
                  if (pend_l == CMD_RESUME) pend_d = CMD_NONE;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end else if (tmr_term) begin
               state_d    = ST_ERR;
               err_dom_d  = k_q;
               req_d[k_q] = 1'b0;
            end else begin
               tmr_inc = 1'b1;
            end
         end
         ST_RUN: begin
            if (pause_i || (pend_q == CMD_PAUSE)) begin
               state_d = ST_PAUSE;
               k_d     = LAST;
               pend_d  = CMD_NONE;
               tmr_clr = 1'b1;
            end
         end
         ST_PAUSE: begin
            pend_d = pend_l;
            if (dom_pause_ack_i[k_q]) begin
               req_d[k_q] = 1'b1;
               tmr_clr    = 1'b1;
               if (k_q == '0) begin
                  state_d = ST_PAUSED;
                  if (pend_l == CMD_PAUSE) pend_d = CMD_NONE;
               end else begin
                  k_d = k_q - KW'(1);
               end
            end else if (tmr_term) begin
               state_d    = ST_ERR;
               err_dom_d  = k_q;
               req_d[k_q] = 1'b1;
            end else begin
               tmr_inc = 1'b1;
            end
         end
         ST_PAUSED: begin
            if (resume_i || (pend_q == CMD_RESUME)) begin
               state_d = ST_RESUME;
               k_d     = '0;
               pend_d  = CMD_NONE;
               tmr_clr = 1'b1;
            end
         end
         ST_ERR: begin
         end
         default: begin
         end
      endcase
   end

   // Outputs: the domain under handshake sees its target level immediately.
   always_comb begin
      dom_rst_o       = dom_rst_q;
      dom_pause_req_o = req_q;
      if (state_q == ST_RESUME) begin
         dom_pause_req_o[k_q] = 1'b0;
      end else if (state_q == ST_PAUSE) begin
         dom_pause_req_o[k_q] = 1'b1;
      end
      busy_o    = (state_q != ST_RUN) && (state_q != ST_PAUSED);
      running_o = (state_q == ST_RUN);
      err_o     = (state_q == ST_ERR);
      err_dom_o = err_dom_q;
   end

endmodule
